// File: rtl/masked_or_monitor.sv
// Registered masked-OR hit detector with saturating run-length and event counters,
// plus a HOLD-length run alarm and a sticky alarm flag cleared by `clear`.
module masked_or_monitor #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MASK  = 4'b0111,
  parameter int               CNT_W = 8,
  parameter int               HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             mask_load,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             clear,
  output logic             any,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             alarm,
  output logic             sticky,
  output logic [WIDTH-1:0] mask
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mask;
  logic             r_any;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_evt_cnt;
  logic             r_sticky;
  logic             r_prev_hit;

  logic             w_hit;
  logic [CNT_W-1:0] w_run_next;
  logic [CNT_W-1:0] w_evt_base;
  logic [CNT_W-1:0] w_evt_next;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_hit      = in_valid & (|(din & r_mask));
    w_run_next = r_run_len;
    if (in_valid) begin
      if (w_hit) w_run_next = (r_run_len == CNT_MAX) ? r_run_len : r_run_len + 1'b1;
      else       w_run_next = '0;
    end

    // Clear zeroes the counter first, then this cycle's event may still add one.
    w_evt_base = clear ? '0 : r_evt_cnt;
    w_evt_next = w_evt_base;
    if (w_hit && !r_prev_hit && (w_evt_base != CNT_MAX)) w_evt_next = w_evt_base + 1'b1;

    w_state_next = r_state;
    if (in_valid) begin
      case (r_state)
        S_IDLE:  if (w_hit) w_state_next = (HOLD == 1) ? S_ALARM : S_RUN;
        S_RUN: begin
          if (!w_hit)                    w_state_next = S_IDLE;
          else if (w_run_next == HOLD_V) w_state_next = S_ALARM;
        end
        S_ALARM: if (!w_hit) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mask     <= MASK;
      r_any      <= 1'b0;
      r_run_len  <= '0;
      r_evt_cnt  <= '0;
      r_sticky   <= 1'b0;
      r_prev_hit <= 1'b0;
    end else begin
      if (mask_load) r_mask <= mask_in;
      if (in_valid)  r_any  <= w_hit;
      r_run_len <= w_run_next;
      r_evt_cnt <= w_evt_next;
      r_state   <= w_state_next;
      // After a clear the next valid hit is a fresh event, whatever came before.
      if (clear)         r_prev_hit <= 1'b0;
      else if (in_valid) r_prev_hit <= w_hit;
      if (w_state_next == S_ALARM) r_sticky <= 1'b1;
      else if (clear)              r_sticky <= 1'b0;
    end
  end

  assign any     = r_any;
  assign run_len = r_run_len;
  assign evt_cnt = r_evt_cnt;
  assign alarm   = (r_state == S_ALARM);
  assign sticky  = r_sticky;
  assign mask    = r_mask;

endmodule

// File: tb/tb_masked_or_monitor.sv
// Directed bench for masked_or_monitor: a vector table for the single-cycle behaviour
// and hand-written loops for saturation of run_len and evt_cnt.
module tb_masked_or_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] din = '0;
  logic       mask_load = 1'b0;
  logic [3:0] mask_in = '0;
  logic       clear = 1'b0;
  logic       any;
  logic [7:0] run_len;
  logic [7:0] evt_cnt;
  logic       alarm;
  logic       sticky;
  logic [3:0] mask;

  int n_total = 0;
  int n_pass  = 0;

  masked_or_monitor #(.WIDTH(4), .MASK(4'b0111), .CNT_W(8), .HOLD(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .mask_load(mask_load), .mask_in(mask_in), .clear(clear),
    .any(any), .run_len(run_len), .evt_cnt(evt_cnt),
    .alarm(alarm), .sticky(sticky), .mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       in_valid;
    logic [3:0] din;
    logic       mask_load;
    logic [3:0] mask_in;
    logic       clear;
    logic       e_any;
    logic [7:0] e_run;
    logic [7:0] e_evt;
    logic       e_alarm;
    logic       e_sticky;
    logic [3:0] e_mask;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic v, input logic [3:0] d,
                              input logic ml, input logic [3:0] mi, input logic c,
                              input logic ea, input logic [7:0] er, input logic [7:0] ee,
                              input logic eal, input logic es, input logic [3:0] em);
    vec_t x;
    x.name = nm; x.rst = r; x.in_valid = v; x.din = d; x.mask_load = ml; x.mask_in = mi;
    x.clear = c; x.e_any = ea; x.e_run = er; x.e_evt = ee; x.e_alarm = eal;
    x.e_sticky = es; x.e_mask = em;
    return x;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [3:0] d,
                       input logic ml, input logic [3:0] mi, input logic c);
    rst = r; in_valid = v; din = d; mask_load = ml; mask_in = mi; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    drive(x.rst, x.in_valid, x.din, x.mask_load, x.mask_in, x.clear);
    check({x.name, ".any"},     32'(any),     32'(x.e_any));
    check({x.name, ".run_len"}, 32'(run_len), 32'(x.e_run));
    check({x.name, ".evt_cnt"}, 32'(evt_cnt), 32'(x.e_evt));
    check({x.name, ".alarm"},   32'(alarm),   32'(x.e_alarm));
    check({x.name, ".sticky"},  32'(sticky),  32'(x.e_sticky));
    check({x.name, ".mask"},    32'(mask),    32'(x.e_mask));
  endtask

  initial begin
    //           name        rst v  din     ml mi      clr any run evt al st mask
    t1.push_back(mk("reset",  1, 0, 4'h0,   0, 4'h0,   0,  0,  0,  0,  0, 0, 4'b0111));
    for (int i = 0; i < 5; i++)
      t1.push_back(mk("msb_masked", 0, 1, 4'b1000, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0111));
    t1.push_back(mk("run1",   0, 1, 4'b0001, 0, 4'h0,   0,  1,  1,  1,  0, 0, 4'b0111));
    t1.push_back(mk("run2",   0, 1, 4'b0001, 0, 4'h0,   0,  1,  2,  1,  0, 0, 4'b0111));
    t1.push_back(mk("run3",   0, 1, 4'b0001, 0, 4'h0,   0,  1,  3,  1,  1, 1, 4'b0111));
    t1.push_back(mk("run_end",0, 1, 4'b0000, 0, 4'h0,   0,  0,  0,  1,  0, 1, 4'b0111));
    t1.push_back(mk("clr_idle",0,0, 4'b0000, 0, 4'h0,   1,  0,  0,  0,  0, 0, 4'b0111));
    t1.push_back(mk("gap_a",  0, 1, 4'b0010, 0, 4'h0,   0,  1,  1,  1,  0, 0, 4'b0111));
    t1.push_back(mk("gap_b",  0, 0, 4'b0010, 0, 4'h0,   0,  1,  1,  1,  0, 0, 4'b0111));
    t1.push_back(mk("gap_c",  0, 1, 4'b0010, 0, 4'h0,   0,  1,  2,  1,  0, 0, 4'b0111));
    t1.push_back(mk("gap_d",  0, 1, 4'b0000, 0, 4'h0,   0,  0,  0,  1,  0, 0, 4'b0111));
    t1.push_back(mk("gap_e",  0, 1, 4'b0100, 0, 4'h0,   0,  1,  1,  2,  0, 0, 4'b0111));
    t1.push_back(mk("mload",  0, 1, 4'b1000, 1, 4'b1000,0,  0,  0,  2,  0, 0, 4'b1000));
    t1.push_back(mk("mnew",   0, 1, 4'b1000, 0, 4'h0,   0,  1,  1,  3,  0, 0, 4'b1000));
    t1.push_back(mk("mrest",  0, 1, 4'b0000, 1, 4'b0111,0,  0,  0,  3,  0, 0, 4'b0111));

    t2.push_back(mk("clr_alarm",0,1,4'b0001, 0, 4'h0,   1,  1,255,  0,  1, 1, 4'b0111));
    t2.push_back(mk("brk",    0, 1, 4'b0000, 0, 4'h0,   0,  0,  0,  0,  0, 1, 4'b0111));
    t2.push_back(mk("re1",    0, 1, 4'b0001, 0, 4'h0,   0,  1,  1,  1,  0, 1, 4'b0111));
    t2.push_back(mk("re2",    0, 1, 4'b0001, 0, 4'h0,   0,  1,  2,  1,  0, 1, 4'b0111));
    t2.push_back(mk("clr_gap",0, 0, 4'b0000, 0, 4'h0,   1,  1,  2,  0,  0, 0, 4'b0111));
    t2.push_back(mk("clr_enter",0,1,4'b0001, 0, 4'h0,   1,  1,  3,  1,  1, 1, 4'b0111));
    t2.push_back(mk("brk2",   0, 1, 4'b0000, 0, 4'h0,   0,  0,  0,  1,  0, 1, 4'b0111));
    t2.push_back(mk("pre1",   0, 1, 4'b0001, 0, 4'h0,   0,  1,  1,  2,  0, 1, 4'b0111));
    t2.push_back(mk("pre2",   0, 1, 4'b0001, 0, 4'h0,   0,  1,  2,  2,  0, 1, 4'b0111));
    t2.push_back(mk("rst_mid",1, 1, 4'b0001, 1, 4'b1111,1,  0,  0,  0,  0, 0, 4'b0111));
    t2.push_back(mk("post1",  0, 1, 4'b0001, 0, 4'h0,   0,  1,  1,  1,  0, 0, 4'b0111));
    t2.push_back(mk("post2",  0, 1, 4'b0001, 0, 4'h0,   0,  1,  2,  1,  0, 0, 4'b0111));
    t2.push_back(mk("post3",  0, 1, 4'b0001, 0, 4'h0,   0,  1,  3,  1,  1, 1, 4'b0111));
    t2.push_back(mk("post_brk",0,1, 4'b0000, 0, 4'h0,   0,  0,  0,  1,  0, 1, 4'b0111));
    t2.push_back(mk("post_hit",0,1, 4'b0001, 0, 4'h0,   0,  1,  1,  2,  0, 1, 4'b0111));

    foreach (t1[i]) apply(t1[i]);

    // 300 consecutive hits: run_len climbs to 255 and sticks; one event only.
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 4'b0001, 0, 4'h0, 0);
      check("sat_run.run_len", 32'(run_len), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      if (i >= 2) check("sat_run.alarm", 32'(alarm), 32'd1);
    end
    check("sat_run.evt_cnt", 32'(evt_cnt), 32'd4);
    check("sat_run.sticky",  32'(sticky),  32'd1);

    foreach (t2[i]) apply(t2[i]);

    // Alternating non-hit/hit pairs: each hit is an event, evt_cnt saturates at 255.
    for (int k = 0; k < 260; k++) begin
      drive(0, 1, 4'b0000, 0, 4'h0, 0);
      drive(0, 1, 4'b0100, 0, 4'h0, 0);
      check("evt_sat.evt_cnt", 32'(evt_cnt), (k + 3 > 255) ? 32'd255 : 32'(k + 3));
    end
    check("evt_sat.run_len", 32'(run_len), 32'd1);
    check("evt_sat.alarm",   32'(alarm),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
